// File: rtl/dbus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbus_pkg
// Brief    : Shared types and constants for the data-bus controller.
// Revision : 1.0 - initial release
// ============================================================================
package dbus_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_CAP  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TGT_NONE  = 2'd0,
        TGT_DMEM  = 2'd1,
        TGT_TBMAN = 2'd2
    } target_t;

endpackage : dbus_pkg
`default_nettype wire

// File: rtl/dbus_decode.sv
`default_nettype none
// ============================================================================
// Module   : dbus_decode
// Brief    : Combinational address-to-target decode for the data-side slaves.
// Revision : 1.0 - initial release
// ============================================================================
module dbus_decode
    import dbus_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = 32'h1000_0000,
    parameter int          DMEM_AW    = 16,
    parameter logic [31:0] TBMAN_BASE = 32'h8000_0000,
    parameter int          TBMAN_AW   = 8
) (
    input  logic [31:0] addr,
    output target_t     tgt
);

    logic w_dmem_hit;
    logic w_tbman_hit;

    // XOR-then-shift compares only the bits above the window size.
    assign w_dmem_hit  = ((addr ^ DMEM_BASE)  >> DMEM_AW)  == 32'd0;
    assign w_tbman_hit = ((addr ^ TBMAN_BASE) >> TBMAN_AW) == 32'd0;

    always_comb begin
        tgt = TGT_NONE;
        if (w_dmem_hit) begin
            tgt = TGT_DMEM;
        end else if (w_tbman_hit) begin
            tgt = TGT_TBMAN;
        end
    end

endmodule : dbus_decode
`default_nettype wire

// File: rtl/dbus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dbus_ctrl
// Brief    : Single-outstanding data-bus controller with chip selects,
//            programmable TBMAN wait states and error response for holes.
// Revision : 1.0 - initial release
// ============================================================================
module dbus_ctrl
    import dbus_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = 32'h1000_0000,
    parameter int          DMEM_AW    = 16,
    parameter logic [31:0] TBMAN_BASE = 32'h8000_0000,
    parameter int          TBMAN_AW   = 8,
    parameter int          TBMAN_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        cs_dmem_n,
    output logic        cs_tbman_n,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] read_data_dmem,
    input  logic [31:0] read_data_tbman
);

    localparam logic [WAIT_W-1:0] c_wait_init = WAIT_W'(TBMAN_WAIT);

    target_t           w_tgt;
    state_t            r_state;
    target_t           r_tgt;
    logic [WAIT_W-1:0] r_cnt;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rdata;
    logic              r_rsp_err;
    logic              r_cs_dmem_n;
    logic              r_cs_tbman_n;
    logic [31:0]       r_mem_addr;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;

    dbus_decode #(
        .DMEM_BASE  (DMEM_BASE),
        .DMEM_AW    (DMEM_AW),
        .TBMAN_BASE (TBMAN_BASE),
        .TBMAN_AW   (TBMAN_AW)
    ) u_decode (
        .addr (req_addr),
        .tgt  (w_tgt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tgt        <= TGT_NONE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rdata      <= '0;
            r_rsp_err    <= 1'b0;
            r_cs_dmem_n  <= 1'b1;
            r_cs_tbman_n <= 1'b1;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_tgt       <= w_tgt;
                        r_mem_addr  <= req_addr;
                        r_mem_we    <= req_we;
                        r_mem_be    <= req_be;
                        r_mem_wdata <= req_wdata;
                        r_cnt       <= (w_tgt == TGT_TBMAN) ? c_wait_init : '0;
                        case (w_tgt)
                            TGT_DMEM: begin
                                r_cs_dmem_n <= 1'b0;
                                r_state     <= ST_ACC;
                            end
                            TGT_TBMAN: begin
                                r_cs_tbman_n <= 1'b0;
                                r_state      <= ST_ACC;
                            end
                            default: begin
                                // Unmapped: skip the bus entirely and answer with an error.
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= 1'b1;
                                r_state     <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_ACC: begin
                    if (r_cnt == '0) begin
                        r_cs_dmem_n  <= 1'b1;
                        r_cs_tbman_n <= 1'b1;
                        r_state      <= ST_CAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_CAP: begin
                    r_rsp_valid <= 1'b1;
                    if (r_mem_we) begin
                        r_rdata <= '0;
                    end else if (r_tgt == TGT_TBMAN) begin
                        r_rdata <= read_data_tbman;
                    end else begin
                        r_rdata <= read_data_dmem;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rdata     <= '0;
                    r_rsp_err   <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rdata;
    assign rsp_err    = r_rsp_err;
    assign cs_dmem_n  = r_cs_dmem_n;
    assign cs_tbman_n = r_cs_tbman_n;
    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;

endmodule : dbus_ctrl
`default_nettype wire

// File: tb/tb_dbus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_ctrl
// Brief    : Directed self-checking bench for dbus_ctrl (default and zero-wait).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_valid0;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] rd_dmem;
    logic [31:0] rd_tbman;

    logic        req_ready, rsp_valid, rsp_err, cs_dmem_n, cs_tbman_n, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        req_ready0, rsp_valid0, rsp_err0, cs_dmem_n0, cs_tbman_n0, mem_we0;
    logic [31:0] rsp_rdata0, mem_addr0, mem_wdata0;
    logic [3:0]  mem_be0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_seen;

    dbus_ctrl u_dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_be          (req_be),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .cs_dmem_n       (cs_dmem_n),
        .cs_tbman_n      (cs_tbman_n),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .read_data_dmem  (rd_dmem),
        .read_data_tbman (rd_tbman)
    );

    dbus_ctrl #(.TBMAN_WAIT(0)) u_dut0 (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid0),
        .req_ready       (req_ready0),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_be          (req_be),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid0),
        .rsp_rdata       (rsp_rdata0),
        .rsp_err         (rsp_err0),
        .cs_dmem_n       (cs_dmem_n0),
        .cs_tbman_n      (cs_tbman_n0),
        .mem_addr        (mem_addr0),
        .mem_we          (mem_we0),
        .mem_be          (mem_be0),
        .mem_wdata       (mem_wdata0),
        .read_data_dmem  (rd_dmem),
        .read_data_tbman (rd_tbman)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = 4'hF;
        req_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; req_we = 1'b0;
        req_addr = '0; req_be = '0; req_wdata = '0; rd_dmem = '0; rd_tbman = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        check("rst_cs_dmem", cs_dmem_n, 1);
        check("rst_cs_tbman", cs_tbman_n, 1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);

        // DMEM read
        @(negedge clk);
        rd_dmem = 32'hDEAD_BEEF;
        drive(1'b0, 32'h1000_0010, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        check("dm_acc_cs", cs_dmem_n, 0);
        check("dm_acc_cs_tb", cs_tbman_n, 1);
        check("dm_acc_ready", req_ready, 0);
        check("dm_acc_addr", mem_addr, 32'h1000_0010);
        @(negedge clk);
        check("dm_cap_cs", cs_dmem_n, 1);
        check("dm_cap_rsp", rsp_valid, 0);
        @(negedge clk);
        check("dm_rsp_valid", rsp_valid, 1);
        check("dm_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("dm_rsp_err", rsp_err, 0);
        @(negedge clk);
        check("dm_idle_valid", rsp_valid, 0);
        check("dm_idle_rdata", rsp_rdata, 0);
        check("dm_idle_ready", req_ready, 1);

        // TBMAN write, three ACC cycles with default wait of 2
        rd_tbman = 32'hCAFE_F00D;
        drive(1'b1, 32'h8000_0004, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            check("tb_acc_cs", cs_tbman_n, 0);
            check("tb_acc_cs_dm", cs_dmem_n, 1);
        end
        check("tb_acc_we", mem_we, 1);
        check("tb_acc_addr", mem_addr, 32'h8000_0004);
        check("tb_acc_wdata", mem_wdata, 32'h1);
        @(negedge clk);
        check("tb_cap_cs", cs_tbman_n, 1);
        check("tb_cap_rsp", rsp_valid, 0);
        @(negedge clk);
        check("tb_rsp_valid", rsp_valid, 1);
        check("tb_rsp_rdata", rsp_rdata, 0);
        check("tb_rsp_err", rsp_err, 0);
        @(negedge clk);

        // Unmapped read
        drive(1'b0, 32'h4000_0000, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        check("un_rsp_valid", rsp_valid, 1);
        check("un_rsp_err", rsp_err, 1);
        check("un_rsp_rdata", rsp_rdata, 0);
        check("un_cs_dmem", cs_dmem_n, 1);
        check("un_cs_tbman", cs_tbman_n, 1);
        @(negedge clk);
        check("un_done_valid", rsp_valid, 0);
        check("un_done_err", rsp_err, 0);
        check("un_done_ready", req_ready, 1);

        // Back-to-back DMEM reads with req_valid held
        rd_dmem = 32'h1111_2222;
        drive(1'b0, 32'h1000_0020, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("b2b_ready", req_ready, (i == 4) ? 32'd1 : 32'd0);
            if (i == 3) begin
                check("b2b_rsp1", rsp_rdata, 32'h1111_2222);
            end
        end
        rd_dmem  = 32'h0000_55AA;
        req_addr = 32'h1000_0024;
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_acc2_cs", cs_dmem_n, 0);
        check("b2b_acc2_addr", mem_addr, 32'h1000_0024);
        repeat (2) @(negedge clk);
        check("b2b_rsp2_valid", rsp_valid, 1);
        check("b2b_rsp2_rdata", rsp_rdata, 32'h0000_55AA);
        @(negedge clk);

        // Reset during second TBMAN ACC cycle
        drive(1'b0, 32'h8000_0010, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        check("rs_acc1_cs", cs_tbman_n, 0);
        @(posedge clk);
        #2;
        check("rs_acc2_cs", cs_tbman_n, 0);
        rst = 1'b1;
        #1;
        check("rs_cs_tbman", cs_tbman_n, 1);
        check("rs_ready", req_ready, 1);
        check("rs_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        n_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) n_seen++;
        end
        check("rs_no_rsp", n_seen, 0);
        rd_dmem = 32'h0BAD_F00D;
        drive(1'b0, 32'h1000_0040, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        check("rs_dm_cs", cs_dmem_n, 0);
        repeat (2) @(negedge clk);
        check("rs_dm_valid", rsp_valid, 1);
        check("rs_dm_rdata", rsp_rdata, 32'h0BAD_F00D);
        @(negedge clk);

        // TBMAN_WAIT=0 instance
        rd_tbman   = 32'h1234_5678;
        req_we     = 1'b0;
        req_addr   = 32'h8000_0000;
        req_valid0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0;
        check("w0_acc_cs", cs_tbman_n0, 0);
        @(negedge clk);
        check("w0_cap_cs", cs_tbman_n0, 1);
        check("w0_cap_rsp", rsp_valid0, 0);
        @(negedge clk);
        check("w0_rsp_valid", rsp_valid0, 1);
        check("w0_rsp_rdata", rsp_rdata0, 32'h1234_5678);
        check("w0_rsp_err", rsp_err0, 0);
        @(negedge clk);
        check("w0_idle_ready", req_ready0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dbus_ctrl
`default_nettype wire

// File: doc/dbus_ctrl.md
# dbus_ctrl

Data-bus controller between the CPU load/store stage and the data-side slaves (data memory, testbench manager TBMAN). It accepts one request at a time, decodes the address, drives the active-low chip selects and shared address/write bus, inserts programmable wait states for TBMAN, and returns selected read data with a one-cycle response pulse. Unmapped addresses return an error response and assert no chip select.

## Interface
- DMEM_BASE, 32'h1000_0000, DMEM window base (aligned to 2^DMEM_AW)
- DMEM_AW, 16, DMEM window size as byte-address bits
- TBMAN_BASE, 32'h8000_0000, TBMAN window base (aligned to 2^TBMAN_AW)
- TBMAN_AW, 8, TBMAN window size as byte-address bits
- TBMAN_WAIT, 2, extra TBMAN access cycles, 0..15
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  CPU request present, held until accepted
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = write
- req_addr  in  32  byte address
- req_be  in  4  byte enables
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data; 0 for writes, errors, and when rsp_valid=0
- rsp_err  out  1  unmapped address, valid with rsp_valid
- cs_dmem_n  out  1  DMEM select, active-low
- cs_tbman_n  out  1  TBMAN select, active-low
- mem_addr, mem_we, mem_be, mem_wdata  out  32/1/4/32  shared slave bus
- read_data_dmem  in  32  DMEM read data
- read_data_tbman  in  32  TBMAN read data

## Operation
- Decode: DMEM hit if req_addr[31:DMEM_AW]==DMEM_BASE[31:DMEM_AW]; TBMAN hit likewise; DMEM wins on overlap; otherwise NONE.
- Handshake completes on the clk edge where req_valid && req_ready. The controller registers the target, mem_addr, mem_we, mem_be, and mem_wdata. These hold until return to IDLE.
- FSM:
  - IDLE: req_ready=1. On accept, go to ACC for DMEM/TBMAN, or to RESP with err for NONE.
  - ACC: the selected cs_*_n is driven low, registered. DMEM stays 1 cycle. TBMAN stays TBMAN_WAIT+1 cycles, with the wait counter loaded with TBMAN_WAIT on accept and decremented each ACC cycle. Exit when the counter is 0, then go to CAP.
  - CAP: all cs high. rdata_q captures read_data_dmem or read_data_tbman per registered target; writes capture 0. Go to RESP.
  - RESP: rsp_valid=1, rsp_rdata=rdata_q, rsp_err per target. Go to IDLE.
- Requests presented outside IDLE are not accepted; the requester holds them.
- Never more than one cs low; never cs low outside ACC.

## Timing
- Reset values: req_ready=1 after reset; rsp_valid=0, rsp_rdata=0, rsp_err=0; cs_dmem_n=1, cs_tbman_n=1; mem_* = 0; state IDLE, counter 0.
- rst assertion mid-transaction takes effect immediately (async): cs deasserts, the response is dropped, and the controller enters IDLE.
- Accept at edge N:
  - DMEM: ACC cycle N+1, CAP N+2, rsp_valid during cycle N+3.
  - TBMAN: ACC N+1..N+1+TBMAN_WAIT, CAP N+2+TBMAN_WAIT, RESP N+3+TBMAN_WAIT.
  - NONE: RESP during N+1.
- Read data is sampled only at the end of CAP; slave data must be valid then.
- Throughput: next accept no earlier than the edge ending RESP's following IDLE cycle. Minimum DMEM request spacing is 4 cycles.
- Counter width is 4 bits; TBMAN_WAIT=0 gives a single ACC cycle identical to DMEM.

## Structure
- Package dbus_pkg contains:
  - state enum {ST_IDLE, ST_ACC, ST_CAP, ST_RESP}
  - target enum {TGT_NONE, TGT_DMEM, TGT_TBMAN}
  - the WAIT_W=4 constant
- Sub-module dbus_decode: combinational address → target using the window parameters.
- All outputs are driven from registers or directly from the state/rdata_q registers; there are no combinational paths from req_* to cs_*.

## Test plan
Default parameters throughout.
- DMEM read: read 0x1000_0010 with read_data_dmem=32'hDEAD_BEEF. Expect cs_dmem_n low exactly 1 cycle, then rsp_valid at accept+3 with rdata=DEAD_BEEF and err=0.
- TBMAN write: write 0x8000_0004, wdata=1, be=4'hF. Expect cs_tbman_n low 3 cycles with mem_we=1 and mem_addr=0x8000_0004, then rsp at accept+5 with rdata=0.
- Unmapped read: read 0x4000_0000. Expect no cs, then rsp_valid at accept+1 with err=1 and rdata=0.
- Back-to-back: req_valid held through two DMEM reads. Expect the second accept exactly 4 cycles after the first, with req_ready=0 in ACC/CAP/RESP.
- Reset in TBMAN ACC: assert rst in the second ACC cycle. Expect cs_tbman_n=1 in the same cycle and no rsp_valid; a subsequent DMEM read completes normally.
- TBMAN_WAIT=0 instance: TBMAN read of 0x8000_0000 with data 32'h1234_5678. Expect one ACC cycle, then rsp at accept+3.
